combo_move_engine: RTL and testbench

//  Parametrised combo recogniser between the button debouncers and game state.

---
 rtl/combo_pkg.sv | 50 +++++
 rtl/combo_matcher.sv | 61 ++++++
 rtl/combo_move_engine.sv | 139 +++++++++++++
 tb/tb_combo_move_engine.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/combo_pkg.sv
// Shared token encodings, widths and the default combo table for the combo move engine.
package combo_pkg;

    localparam int TOK_W = 3;

    localparam logic [TOK_W-1:0] TOK_NONE   = 3'd0;
    localparam logic [TOK_W-1:0] TOK_UP     = 3'd1;
    localparam logic [TOK_W-1:0] TOK_DOWN   = 3'd2;
    localparam logic [TOK_W-1:0] TOK_LEFT   = 3'd3;
    localparam logic [TOK_W-1:0] TOK_RIGHT  = 3'd4;
    localparam logic [TOK_W-1:0] TOK_ATTACK = 3'd5;

    localparam int DEF_NUM_COMBOS  = 3;
    localparam int DEF_MAX_SEQ_LEN = 10;
    localparam int DEF_SEQ_W       = DEF_NUM_COMBOS * DEF_MAX_SEQ_LEN * TOK_W;

    // Places token j of combo k (1-based k) into a packed sequence table.
    function automatic logic [DEF_SEQ_W-1:0] put_tok(input logic [DEF_SEQ_W-1:0] v,
                                                     input int k, input int j,
                                                     input logic [TOK_W-1:0] t);
        logic [DEF_SEQ_W-1:0] r;
        r = v;
        r[((k - 1) * DEF_MAX_SEQ_LEN + j) * TOK_W +: TOK_W] = t;
        return r;
    endfunction

    function automatic logic [DEF_SEQ_W-1:0] default_seq();
        logic [DEF_SEQ_W-1:0] s;
        s = '0;
        s = put_tok(s, 1, 0, TOK_ATTACK);
        s = put_tok(s, 2, 0, TOK_LEFT);
        s = put_tok(s, 2, 1, TOK_DOWN);
        s = put_tok(s, 2, 2, TOK_RIGHT);
        s = put_tok(s, 2, 3, TOK_ATTACK);
        s = put_tok(s, 3, 0, TOK_UP);
        s = put_tok(s, 3, 1, TOK_UP);
        s = put_tok(s, 3, 2, TOK_DOWN);
        s = put_tok(s, 3, 3, TOK_DOWN);
        s = put_tok(s, 3, 4, TOK_LEFT);
        s = put_tok(s, 3, 5, TOK_RIGHT);
        s = put_tok(s, 3, 6, TOK_LEFT);
        s = put_tok(s, 3, 7, TOK_RIGHT);
        s = put_tok(s, 3, 8, TOK_ATTACK);
        return s;
    endfunction

    localparam logic [DEF_SEQ_W-1:0]          DEF_COMBO_SEQ = default_seq();
    localparam logic [DEF_NUM_COMBOS*4-1:0]   DEF_COMBO_LEN = {4'd9, 4'd4, 4'd1};

endpackage

// File: rtl/combo_matcher.sv
// Tracks progress through one combo sequence; pulses match_o for one cycle on completion.
module combo_matcher
    import combo_pkg::*;
#(
    parameter int                           LEN         = 1,
    parameter int                           MAX_SEQ_LEN = DEF_MAX_SEQ_LEN,
    parameter logic [MAX_SEQ_LEN*TOK_W-1:0] SEQ         = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             tok_valid_i,
    input  logic [TOK_W-1:0] tok_i,
    output logic             match_o,
    output logic             busy_o
);

    localparam int             IW   = $clog2(MAX_SEQ_LEN + 1);
    localparam logic [IW-1:0]  LAST = IW'((LEN > 0) ? LEN - 1 : 0);

    logic [IW-1:0]    idx_q;
    logic             match_q;
    logic [TOK_W-1:0] exp_tok;
    logic [TOK_W-1:0] first_tok;

    assign exp_tok   = SEQ[idx_q * TOK_W +: TOK_W];
    assign first_tok = SEQ[TOK_W-1:0];

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            idx_q   <= '0;
            match_q <= 1'b0;
        end else begin
            match_q <= 1'b0;
            if (tok_valid_i && (LEN > 0)) begin
                if (tok_i == exp_tok) begin
                    if (idx_q == LAST) begin
                        match_q <= 1'b1;
                        idx_q   <= '0;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                    end
                end else if (tok_i == first_tok) begin
                    // A wrong token may still be a fresh start of this sequence.
                    if (LAST == '0) begin
                        match_q <= 1'b1;
                        idx_q   <= '0;
                    end else begin
                        idx_q   <= IW'(1);
                    end
                end else begin
                    idx_q <= '0;
                end
            end
        end
    end

    assign match_o = match_q;
    assign busy_o  = (idx_q != '0);

endmodule

// File: rtl/combo_move_engine.sv
// Combo recogniser: edge detect, token priority, gap timer, match resolve, output registers.
// Optional AI override path enabled by defining COMBO_AI_BYPASS_EN.
module combo_move_engine
    import combo_pkg::*;
#(
    parameter int                                    NUM_COMBOS  = DEF_NUM_COMBOS,
    parameter int                                    MAX_SEQ_LEN = DEF_MAX_SEQ_LEN,
    parameter int                                    GAP_CYCLES  = 25_000_000,
    parameter logic [NUM_COMBOS*MAX_SEQ_LEN*TOK_W-1:0] COMBO_SEQ = DEF_COMBO_SEQ,
    parameter logic [NUM_COMBOS*4-1:0]               COMBO_LEN   = DEF_COMBO_LEN,
    localparam int                                   CW          = $clog2(NUM_COMBOS + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          up_i,
    input  logic          down_i,
    input  logic          left_i,
    input  logic          right_i,
    input  logic          attack_i,
    input  logic          attack_allowed_i,
`ifdef COMBO_AI_BYPASS_EN
    input  logic          ai_bypass_i,
    input  logic          ai_strobe_i,
    input  logic [CW-1:0] ai_combo_i,
`endif
    output logic          combo_strobe_o,
    output logic [CW-1:0] combo_move_o,
    output logic          busy_o
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    logic [4:0]            lvl;
    logic [4:0]            prev_q;
    logic [4:0]            rise;
    logic [TOK_W-1:0]      tok_d, tok_q;
    logic                  tok_vld_d, tok_vld_q;
    logic [GW-1:0]         gap_d, gap_q;
    logic                  timeout;
    logic                  bypass;
    logic [NUM_COMBOS-1:0] match;
    logic [NUM_COMBOS-1:0] mbusy;
    logic                  any_match;
    logic                  clear;
    logic [CW-1:0]         sel;
    logic                  strobe_d, strobe_q;
    logic [CW-1:0]         move_d, move_q;

`ifdef COMBO_AI_BYPASS_EN
    assign bypass = ai_bypass_i;
`else
    assign bypass = 1'b0;
`endif

    assign lvl  = {attack_i, up_i, down_i, left_i, right_i};
    assign rise = lvl & ~prev_q;

    always_comb begin
        tok_d = TOK_NONE;
        if      (rise[4]) tok_d = TOK_ATTACK;
        else if (rise[3]) tok_d = TOK_UP;
        else if (rise[2]) tok_d = TOK_DOWN;
        else if (rise[1]) tok_d = TOK_LEFT;
        else if (rise[0]) tok_d = TOK_RIGHT;
    end

    assign tok_vld_d = (tok_d != TOK_NONE) && !bypass;

    // Timer measures idle time since the last token the matchers consumed.
    always_comb begin
        gap_d = gap_q;
        if (tok_vld_q)                     gap_d = '0;
        else if (gap_q != GW'(GAP_CYCLES)) gap_d = gap_q + GW'(1);
    end

    assign busy_o    = |mbusy;
    assign timeout   = busy_o && (gap_q == GW'(GAP_CYCLES)) && !tok_vld_q;
    assign any_match = |match;
    assign clear     = any_match || timeout || bypass;

    for (genvar k = 0; k < NUM_COMBOS; k++) begin : g_match
        if (int'(COMBO_LEN[k*4 +: 4]) > MAX_SEQ_LEN) begin : g_bad_len
            $error("combo_move_engine: COMBO_LEN of combo %0d exceeds MAX_SEQ_LEN", k + 1);
        end
        combo_matcher #(
            .LEN         (int'(COMBO_LEN[k*4 +: 4])),
            .MAX_SEQ_LEN (MAX_SEQ_LEN),
            .SEQ         (COMBO_SEQ[k*MAX_SEQ_LEN*TOK_W +: MAX_SEQ_LEN*TOK_W])
        ) u_matcher (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .clear_i     (clear),
            .tok_valid_i (tok_vld_q),
            .tok_i       (tok_q),
            .match_o     (match[k]),
            .busy_o      (mbusy[k])
        );
    end

    always_comb begin
        sel = '0;
        for (int k = 1; k <= NUM_COMBOS; k++) begin
            if (match[k-1]) sel = CW'(k);
        end
    end

    always_comb begin
        strobe_d = any_match && attack_allowed_i;
        move_d   = strobe_d ? sel : '0;
`ifdef COMBO_AI_BYPASS_EN
        if (ai_bypass_i) begin
            strobe_d = ai_strobe_i && attack_allowed_i;
            move_d   = strobe_d ? ai_combo_i : '0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_q    <= '0;
            tok_q     <= TOK_NONE;
            tok_vld_q <= 1'b0;
            gap_q     <= '0;
            strobe_q  <= 1'b0;
            move_q    <= '0;
        end else begin
            prev_q    <= lvl;
            tok_q     <= tok_d;
            tok_vld_q <= tok_vld_d;
            gap_q     <= gap_d;
            strobe_q  <= strobe_d;
            move_q    <= move_d;
        end
    end

    assign combo_strobe_o = strobe_q;
    assign combo_move_o   = move_q;

endmodule

// File: tb/tb_combo_move_engine.sv
// Directed-vector bench for combo_move_engine with a short gap timeout.
module tb_combo_move_engine;

    localparam int CW = 2;

    localparam logic [4:0] B_A = 5'b10000;
    localparam logic [4:0] B_U = 5'b01000;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_L = 5'b00010;
    localparam logic [4:0] B_R = 5'b00001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    btn = '0;
    logic          allowed = 1'b1;
    logic          combo_strobe;
    logic [CW-1:0] combo_move;
    logic          busy;
`ifdef COMBO_AI_BYPASS_EN
    logic          ai_bypass = 1'b0;
    logic          ai_strobe = 1'b0;
    logic [CW-1:0] ai_combo  = '0;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    combo_move_engine #(.GAP_CYCLES(100)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .up_i             (btn[3]),
        .down_i           (btn[2]),
        .left_i           (btn[1]),
        .right_i          (btn[0]),
        .attack_i         (btn[4]),
        .attack_allowed_i (allowed),
`ifdef COMBO_AI_BYPASS_EN
        .ai_bypass_i      (ai_bypass),
        .ai_strobe_i      (ai_strobe),
        .ai_combo_i       (ai_combo),
`endif
        .combo_strobe_o   (combo_strobe),
        .combo_move_o     (combo_move),
        .busy_o           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Press buttons in mask m; the strobe must appear only on the 4th negedge (after edge n+2).
    task automatic press(input logic [4:0] m, input int exp, input string tag);
        @(posedge clk); #1 btn = btn | m;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk({tag, "_stb"}, 32'(combo_strobe), 32'((i == 4) && (exp != 0)));
            chk({tag, "_mv"},  32'(combo_move),   (i == 4) ? 32'(exp) : 32'd0);
        end
        @(posedge clk); #1 btn = btn & ~m;
        repeat (3) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stb",  32'(combo_strobe), 32'd0);
        chk("rst_mv",   32'(combo_move),   32'd0);
        chk("rst_busy", 32'(busy),         32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // single attack
        press(B_A, 1, "t1_atk");
        chk("t1_busy", 32'(busy), 32'd0);

        // L,D,R,ATTACK -> 2 beats 1
        press(B_L, 0, "t2_l");
        chk("t2_busy", 32'(busy), 32'd1);
        press(B_D, 0, "t2_d");
        press(B_R, 0, "t2_r");
        press(B_A, 2, "t2_a");
        chk("t2_busy_end", 32'(busy), 32'd0);

        // Konami + attack -> 3
        press(B_U, 0, "t3_u1");
        press(B_U, 0, "t3_u2");
        press(B_D, 0, "t3_d1");
        press(B_D, 0, "t3_d2");
        press(B_L, 0, "t3_l1");
        press(B_R, 0, "t3_r1");
        press(B_L, 0, "t3_l2");
        press(B_R, 0, "t3_r2");
        press(B_A, 3, "t3_a");

        // Konami with a long stall before attack -> only 1
        press(B_U, 0, "t3b_u1");
        press(B_U, 0, "t3b_u2");
        press(B_D, 0, "t3b_d1");
        press(B_D, 0, "t3b_d2");
        press(B_L, 0, "t3b_l1");
        press(B_R, 0, "t3b_r1");
        press(B_L, 0, "t3b_l2");
        press(B_R, 0, "t3b_r2");
        chk("t3b_busy_pre", 32'(busy), 32'd1);
        idle(150);
        @(negedge clk);
        chk("t3b_busy_to", 32'(busy), 32'd0);
        press(B_A, 1, "t3b_a");

        // up and attack together -> attack token only
        press(B_U | B_A, 1, "t4_ua");
        chk("t4_busy", 32'(busy), 32'd0);

        // match discarded while attack not allowed
        press(B_L, 0, "t5_l");
        press(B_D, 0, "t5_d");
        press(B_R, 0, "t5_r");
        @(posedge clk); #1 allowed = 1'b0;
        press(B_A, 0, "t5_a_blk");
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 allowed = 1'b1;
        press(B_A, 1, "t5_a_ok");

        // reset mid-sequence
        press(B_L, 0, "t6_l");
        press(B_D, 0, "t6_d");
        chk("t6_busy_pre", 32'(busy), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_busy_rst", 32'(busy), 32'd0);
        chk("t6_stb_rst",  32'(combo_strobe), 32'd0);
        press(B_R, 0, "t6_r");
        press(B_A, 1, "t6_a");

`ifdef COMBO_AI_BYPASS_EN
        @(posedge clk); #1 ai_bypass = 1'b1; ai_combo = 2'd2; ai_strobe = 1'b1;
        @(posedge clk); #1 ai_strobe = 1'b0;
        @(negedge clk);
        chk("ai_stb", 32'(combo_strobe), 32'd1);
        chk("ai_mv",  32'(combo_move),   32'd2);
        @(negedge clk);
        chk("ai_stb_off", 32'(combo_strobe), 32'd0);
        @(posedge clk); #1 ai_bypass = 1'b0;
`endif

        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
